// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial nibble adder controller.
package serial_add_pkg;

  // Width of one serial digit processed per RUN cycle.
  localparam int NIB_W = 4;

  // Controller states: waiting for operands, rippling nibbles, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add4_core.sv
// Combinational 4-bit adder slice with carry in/out, reused for every nibble.
module add4_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  // Full 5-bit sum; the top bit is the carry into the next nibble.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/serial_nibble_add_ctrl.sv
// Serial nibble-at-a-time adder controller (IDLE -> RUN -> DONE).
// Optional macro SERIAL_ADD_SUB_EN: when defined, a latched sub=1 computes
// a + ~b + carry_in (carry_in=1 gives a-b, carry_out=1 means no borrow).
// Without it the sub port is present but has no effect.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds its data while valid is high and not taken.
module serial_nibble_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                   carry_in,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                   carry_out,
  output logic                   busy,
  output state_e                 dbg_state
);

  localparam int W    = NIB_W * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            sub_q, sub_d;

  logic [NIB_W-1:0] nib_a, nib_b, nib_s;
  logic             nib_co;

  // Select the current nibble; subtraction inverts the b operand.
  assign nib_a = a_q[{idx_q, 2'b00} +: NIB_W];
`ifdef SERIAL_ADD_SUB_EN
  assign nib_b = b_q[{idx_q, 2'b00} +: NIB_W] ^ {NIB_W{sub_q}};
`else
  logic unused_sub;
  assign unused_sub = sub_q;
  assign nib_b = b_q[{idx_q, 2'b00} +: NIB_W];
`endif

  add4_core u_add4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  // Next-state logic: accept in IDLE, ripple one nibble per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = sub;
`else
          sub_d   = 1'b0;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: NIB_W] = nib_s;
        carry_d = nib_co;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_co;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      sub_q   <= sub_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign dbg_state = state_q;

  // sub is only latched when subtraction is built in.
`ifndef SERIAL_ADD_SUB_EN
  logic unused_sub_port;
  assign unused_sub_port = sub;
`endif

endmodule

// File: doc/serial_nibble_add_ctrl.md
SERIAL_NIBBLE_ADD_CTRL -- requirements
Module: serial_nibble_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, the operand width in 4-bit nibbles (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operands offered.
REQ-005 SHALL have port in_ready, output, 1, controller can accept operands.
REQ-006 SHALL have ports a and b, input, 4*NIBBLES each, the operands.
REQ-007 SHALL have port carry_in, input, 1, the initial carry.
REQ-008 SHALL have port sub, input, 1, subtract request (see Configuration).
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 SHALL have port sum, output, 4*NIBBLES, the result.
REQ-012 SHALL have port carry_out, output, 1, the final carry.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 SHALL assert in_ready only in IDLE; acceptance is in_valid && in_ready at a rising edge.
REQ-016 On acceptance, SHALL: latch a, b and carry_in (and sub if enabled); clear the nibble index; enter RUN.
REQ-017 In RUN, SHALL: add nibble k of a and b plus the carry register on each edge, LSB nibble first; write sum nibble k; update the carry register; increment k.
REQ-018 After nibble NIBBLES-1, SHALL enter DONE, with carry_out equal to the final carry; latency is exactly NIBBLES clocks from acceptance to out_valid.
REQ-019 In DONE, SHALL hold out_valid=1 with sum and carry_out stable until out_ready=1 at an edge, then return to IDLE.
REQ-020 SHALL hold sum and carry_out at their last values in IDLE; out_valid stays 0 outside DONE.
REQ-021 Result arithmetic SHALL be modulo 2^(4*NIBBLES), with carry_out as bit 4*NIBBLES of the full sum.
REQ-022 SHALL ignore in_valid, a, b, carry_in and sub outside IDLE; an operand change mid-operation does not affect the result.
REQ-023 Minimum initiation interval is NIBBLES+2 clocks (accept, NIBBLES RUN cycles, DONE handshake).

Reset
REQ-024 While rst_n=0, SHALL immediately force: state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0, carry register 0, index 0.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-026 Macro SERIAL_ADD_SUB_EN SHALL enable subtraction: with sub=1 latched, the result is a + ~b + carry_in.
REQ-027 In subtraction, carry_in=1 SHALL yield a-b, and carry_out=1 SHALL mean no borrow.
REQ-028 Without SERIAL_ADD_SUB_EN, the sub port SHALL exist but be ignored, and the result is always a + b + carry_in.

Structure
REQ-029 Package serial_add_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the nibble width constant 4.
REQ-030 The per-nibble adder SHALL be the combinational sub-module add4_core: ports a[3:0], b[3:0], ci → s[3:0], co.
REQ-031 add4_core SHALL be instantiated once and reused every RUN cycle.

Verification (NIBBLES=4)
REQ-032 Add case: accept a=0x1234, b=0x4321, carry_in=0 → sum=0x5555, carry_out=0, with out_valid rising exactly 4 clocks after acceptance.
REQ-033 Full carry ripple: a=0xFFFF, b=0x0001, carry_in=0 → sum=0x0000, carry_out=1; a=0xFFFF, b=0x0000, carry_in=1 → same result.
REQ-034 Backpressure: hold out_ready=0 for 3 clocks in DONE → out_valid, sum and carry_out stable, in_ready=0. Then out_ready=1 → IDLE and in_ready=1 on the next cycle.
REQ-035 Reset abort: drop rst_n in the 2nd RUN cycle → out_valid=0 and in_ready=1 at once. Then a new operation 0x0003+0x0006 → 0x0009.
REQ-036 With SERIAL_ADD_SUB_EN: sub=1, a=0x0005, b=0x0007, carry_in=1 → sum=0xFFFE, carry_out=0; a=0x0007, b=0x0005 → 0x0002, carry_out=1. Without the macro, the same stimulus gives 0x000D and 0x000D.
